// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   8N1 UART transmitter driven by the SEND bit of a control register.
//   When SEND is seen high in IDLE the byte on tx_data_i is captured and sent
//   (start bit, 8 data bits LSB first, stop bit). After the stop bit the
//   block spends one DONE cycle writing the control word back with SEND
//   cleared, through the register's interface-side write port.
//
// Ports
//   clk_i      : system clock, all state changes on the rising edge
//   rst_i      : synchronous active-high reset
//   ctrl_i     : live control register contents, bit 0 = SEND
//   tx_data_i  : byte to send, sampled only when a frame starts
//   wr_ctrl_o  : one-cycle write strobe into the control register (wr2_i)
//   ctrl_o     : write-back word into the control register (in2_i)
//   tx_o       : serial line, idle high
//   busy_o     : high while a frame is in progress
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ctrl_i,
  input  logic [7:0]  tx_data_i,
  output logic        wr_ctrl_o,
  output logic [31:0] ctrl_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [15:0] baud_cnt, baud_cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift, shift_next;
  logic        tx_next, busy_next, wr_next;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State and output registers. Outputs are loaded from the next-state
  // decode so they change on the same edge as the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
      wr_ctrl_o <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      tx_o      <= tx_next;
      busy_o    <= busy_next;
      wr_ctrl_o <= wr_next;
    end
  end

  // Next-state decode. SEND is only looked at in IDLE, so writes to the
  // control register during a frame cannot disturb it.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        if (ctrl_i[0]) begin
          state_next = START;
          shift_next = tx_data_i;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          state_next    = DONE;
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    wr_next   = (state_next == DONE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  // The strobe is registered, but the upper bits come from the live register
  // so any user update made before the DONE cycle is preserved by the
  // read-modify-write.
  assign ctrl_o = wr_ctrl_o ? {ctrl_i[31:1], 1'b0} : 32'h0;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int C  = 4;
  localparam int CS = 1042;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] ctrl_i;
  logic [7:0]  tx_data;
  logic        wr_ctrl, tx, busy;
  logic [31:0] ctrl_o;

  logic [31:0] ctrl_s;
  logic [7:0]  data_s;
  logic        wr_s, tx_s, busy_s;
  logic [31:0] ctrl_o_s;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_i), .tx_data_i(tx_data),
    .wr_ctrl_o(wr_ctrl), .ctrl_o(ctrl_o), .tx_o(tx), .busy_o(busy)
  );

  uart_tx_ctrl dut_slow (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl_s), .tx_data_i(data_s),
    .wr_ctrl_o(wr_s), .ctrl_o(ctrl_o_s), .tx_o(tx_s), .busy_o(busy_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_t = cycles since the frame's start bit appeared on
  // the line (-1 when idle). The frame occupies 10*C cycles on the line and
  // is followed by one write-back cycle at m_t == 10*C.
  int         m_t = -1;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk) begin
    if (rst) m_t = -1;
    else if (m_t < 0) begin
      if (ctrl_i[0] === 1'b1) begin
        m_t    = 0;
        m_byte = tx_data;
      end
    end else if (m_t == 10 * C) m_t = -1;
    else m_t = m_t + 1;
  end

  function automatic logic exp_tx(input int t, input logic [7:0] b);
    if (t < 0 || t >= 9 * C) return 1'b1;
    if (t < C) return 1'b0;
    return b[3'((t - C) / C)];
  endfunction

  logic chk_en = 1'b0;
  int   pulses = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx",     32'(tx),      32'(exp_tx(m_t, m_byte)));
      check("model_busy",   32'(busy),    32'(m_t >= 0));
      check("model_wr",     32'(wr_ctrl), 32'(m_t == 10 * C));
      check("model_ctrl_o", ctrl_o,       (m_t == 10 * C) ? {ctrl_i[31:1], 1'b0} : 32'h0);
      if (wr_ctrl === 1'b1) pulses++;
    end
  end

  // Control register with user-side write priority over the write-back port.
  logic        user_wr   = 1'b0;
  logic [31:0] user_data = 32'h0;

  task automatic cycle();
    logic [31:0] nxt;
    @(negedge clk);
    nxt = ctrl_i;
    if (user_wr) nxt = user_data;
    else if (wr_ctrl === 1'b1) nxt = ctrl_o;
    user_wr = 1'b0;
    @(posedge clk);
    #1;
    ctrl_i = nxt;
  endtask

  task automatic user_write(input logic [31:0] v);
    user_wr   = 1'b1;
    user_data = v;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      cycle();
      n++;
    end
    check("wait_idle_bound", 32'(busy), 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_wr, busy_cnt, p0, n, cnt_low, total;
    logic [31:0] cap;
    logic [39:0] pat;
    logic [7:0]  bits;

    rst = 1'b1; ctrl_i = 32'h0; tx_data = 8'h00; ctrl_s = 32'h0; data_s = 8'h00;
    cycle(); cycle();
    chk_en = 1'b1;
    check("reset_tx",     32'(tx),      32'h1);
    check("reset_busy",   32'(busy),    32'h0);
    check("reset_wr",     32'(wr_ctrl), 32'h0);
    check("reset_ctrl_o", ctrl_o,       32'h0);

    // SEND written while reset is held is ignored until reset drops.
    user_write(32'h1); cycle();
    cycle();
    check("send_in_reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    cycle();
    check("first_edge_after_reset_busy", 32'(busy), 32'h1);
    check("first_edge_after_reset_tx",   32'(tx),   32'h0);
    wait_idle(60);

    // Frame 0xA5: line waveform and write-back edge.
    tx_data = 8'hA5;
    pat = 40'b0000_1111_0000_1111_0000_0000_1111_0000_1111_1111;
    user_write(32'h1); cycle();
    first_wr = -1; cap = 32'hDEAD_BEEF;
    for (int k = 1; k <= 41; k++) begin
      cycle();
      if (k <= 40) check("a5_line", 32'(tx), 32'(pat[40 - k]));
      if (wr_ctrl === 1'b1 && first_wr < 0) begin
        first_wr = k;
        cap      = ctrl_o;
      end
    end
    check("a5_wr_edge",    32'(first_wr), 32'd41);
    check("a5_ctrl_o",     cap,           32'h0);
    cycle();
    check("a5_send_clear", ctrl_i,        32'h0);

    // Upper bits preserved, single pulse, busy length.
    p0 = pulses;
    user_write(32'hF0F0_0003); cycle();
    busy_cnt = 0; cap = 32'h0;
    repeat (50) begin
      cycle();
      if (busy === 1'b1) busy_cnt++;
      if (wr_ctrl === 1'b1) cap = ctrl_o;
    end
    check("f0_busy_cycles", 32'(busy_cnt),   32'd41);
    check("f0_pulses",      32'(pulses - p0), 32'd1);
    check("f0_ctrl_o",      cap,              32'hF0F0_0002);
    check("f0_reg_after",   ctrl_i,           32'hF0F0_0002);

    // 0x3C latched, tx_data toggling, control rewritten mid-frame.
    tx_data = 8'h3C;
    user_write(32'h1); cycle();
    bits = 8'h00; cap = 32'h0;
    for (int k = 1; k <= 42; k++) begin
      cycle();
      tx_data = ~tx_data;
      if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) bits[3'((k - 6) / 4)] = tx;
      if (k == 10) user_write(32'h5555_AAAA);
      if (k == 25) user_write(32'h8000_0001);
      if (wr_ctrl === 1'b1) cap = ctrl_o;
    end
    check("3c_serial_bits", 32'(bits), 32'h3C);
    check("3c_ctrl_o",      cap,       32'h8000_0000);
    check("3c_reg_after",   ctrl_i,    32'h8000_0000);

    // User writes SEND in the DONE cycle: back-to-back frame.
    tx_data = 8'h5A;
    p0 = pulses;
    user_write(32'h1); cycle();
    n = 0;
    while (wr_ctrl !== 1'b1 && n < 60) begin cycle(); n++; end
    check("b2b_first_pulse_seen", 32'(wr_ctrl), 32'h1);
    user_write(32'h1); cycle();
    check("b2b_idle_busy", 32'(busy), 32'h0);
    check("b2b_idle_tx",   32'(tx),   32'h1);
    cycle();
    check("b2b_start_busy", 32'(busy), 32'h1);
    check("b2b_start_tx",   32'(tx),   32'h0);
    wait_idle(60);
    check("b2b_pulses", 32'(pulses - p0), 32'd2);

    // Reset during data bit 3 aborts; SEND still set restarts the frame.
    p0 = pulses;
    user_write(32'h1); cycle();
    repeat (18) cycle();
    rst = 1'b1; cycle();
    check("abort_tx",   32'(tx),      32'h1);
    check("abort_busy", 32'(busy),    32'h0);
    check("abort_wr",   32'(wr_ctrl), 32'h0);
    rst = 1'b0; cycle();
    check("restart_busy", 32'(busy), 32'h1);
    check("restart_tx",   32'(tx),   32'h0);
    wait_idle(60);
    check("abort_pulses", 32'(pulses - p0), 32'd1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      tx_data = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      if (wr_ctrl === 1'b1 && $urandom_range(0, 1) == 1) user_write($urandom | 32'h1);
      else if (busy === 1'b0 && $urandom_range(0, 3) == 0) user_write($urandom | 32'h1);
      else if ($urandom_range(0, 39) == 0) user_write($urandom);
      cycle();
    end
    rst = 1'b0;
    wait_idle(100);

    // Default baud divider, byte 0x00.
    data_s = 8'h00;
    ctrl_s = 32'h1;
    cycle();
    ctrl_s = 32'h0;
    check("slow_start_tx", 32'(tx_s), 32'h0);
    cnt_low = 0;
    while (tx_s === 1'b0 && cnt_low < 20000) begin cnt_low++; cycle(); end
    total = cnt_low;
    while (wr_s !== 1'b1 && total < 20000) begin total++; cycle(); end
    check("slow_low_cycles", 32'(cnt_low), 32'(9 * CS));
    check("slow_frame_cycles", 32'(total), 32'(10 * CS));
    check("slow_ctrl_o", ctrl_o_s, 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
